zaxxon_input: RTL and testbench
===============================

ZAXXON_INPUT -- requirements
Module: zaxxon_input

Interface
REQ-001 Parameter COIN_PULSE, default 240000, meaning coin1 high time in clk_sys cycles (10 ms at 24 MHz); legal range 2..2^20-1.
REQ-002 Parameter SOCD_NEUTRAL, default 1, meaning opposing directions held together resolve to neutral (1) or pass through (0).
REQ-003 clk_sys  in  1  system clock (24 MHz); sole clock.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ps2_key  in  11  keyboard event: [10] toggles per event, [9] pressed, [8] extended, [7:0] scan code.
REQ-006 joy1, joy2  in  16 each  joystick words: [0] right, [1] left, [2] down, [3] up, [4] fire, [6] start1, [7] start2, [8] coin.
REQ-007 p1  out  5  player-1 controls {fire,up,down,left,right}, active-high.
REQ-008 p2  out  5  cocktail controls, same ordering.
REQ-009 start1, start2  out  1 each  start buttons, active-high.
REQ-010 coin1  out  1  shaped coin pulse to core.

Function
REQ-011 Keyboard events shall be accepted only on a cycle where ps2_key[10] differs from its value registered the previous cycle; one event per toggle.
REQ-012 On an accepted event, the latch selected by ps2_key[7:0] shall take ps2_key[9]; ps2_key[8] ignored; unknown codes change nothing.
REQ-013 Code map: 75 up, 72 down, 6B left, 74 right, 14 fire (player 1); 2D up, 2B down, 23 left, 34 right, 1C fire (player 2); 05/16 start1; 06/1E start2; 76/2E coin A; 36 coin B.
REQ-014 Start1/16 and 05 share one latch; likewise start2 and coin A; a release of either code clears the shared latch.
REQ-015 Player-1 raw = keyboard P1 latches OR joy1 bits; player-2 raw = keyboard P2 latches OR joy2 bits.
REQ-016 p1 and p2 shall both equal raw P1 OR raw P2 per bit (shared upright/cocktail controls).
REQ-017 When SOCD_NEUTRAL=1, left and right both set shall output both 0; up and down both set shall output both 0; fire unaffected.
REQ-018 start1 = latch OR joy1[6] OR joy2[6]; start2 = latch OR joy1[7] OR joy2[7].
REQ-019 p1, p2, start1, start2 shall be registered: one clk_sys cycle from joy input change, two cycles from ps2_key toggle.
REQ-020 Coin request = coin A latch OR coin B latch OR joy1[8] OR joy2[8].
REQ-021 Coin FSM states IDLE, PULSE, HOLD; reset state IDLE.
REQ-022 IDLE: request high -> PULSE, load counter with COIN_PULSE-1; coin1 rises the following cycle.
REQ-023 PULSE: coin1=1; counter decrements each cycle; at 0 -> HOLD; coin1 high exactly COIN_PULSE cycles regardless of request duration.
REQ-024 HOLD: coin1=0; request low -> IDLE; request high stays HOLD (no repeat coin while held).
REQ-025 Request dropping and reasserting during PULSE shall not extend or restart the pulse; only the HOLD/IDLE path re-arms.
REQ-026 Counter width 20 bits; no wrap beyond 0.

Reset
REQ-027 reset_n low shall asynchronously clear all key latches, previous-toggle register, outputs p1=0, p2=0, start1=0, start2=0, coin1=0, counter=0, FSM=IDLE.
REQ-028 Reset deassertion is synchronised externally; first toggle comparison after reset uses registered ps2_key[10]=0, so a held ps2_key[10]=1 produces one event.
REQ-029 Reset during PULSE shall drop coin1 immediately; no residual pulse after release.

Verification
REQ-030 ps2_key toggles with {pressed=1,code=75} -> p1=p2=5'b01000 two cycles later; toggle with pressed=0 code=75 -> 0.
REQ-031 joy1[0]=1 and joy2[1]=1 with SOCD_NEUTRAL=1 -> p1[1:0]=00; joy2[1] drops -> p1[1:0]=01 next cycle.
REQ-032 COIN_PULSE=8, joy1[8] high 100 cycles -> coin1 high exactly 8 cycles, once; release then reassert -> second 8-cycle pulse.
REQ-033 COIN_PULSE=8, joy1[8] one-cycle glitch -> full 8-cycle pulse; second glitch 3 cycles later -> no extension, HOLD->IDLE, pulse after end only if request recurs.
REQ-034 Code 05 press, code 16 release -> start1=0; unknown code 0x99 press -> no output change.
REQ-035 reset_n low at pulse cycle 4 -> coin1=0 same cycle asynchronously; after release with request low, coin1 stays 0.

Source files
------------

// File: rtl/zaxxon_input_if.sv
// zaxxon_input_if
// Bundles the player-input signals of the Zaxxon input block.
//   ps2_key        : keyboard event word {toggle, pressed, extended, code[7:0]}
//   joy1, joy2     : joystick words (right, left, down, up, fire, -, start1, start2, coin)
//   p1, p2         : shared control outputs {fire, up, down, left, right}
//   start1, start2 : start button outputs
//   coin1          : shaped coin pulse
// master drives the raw inputs and observes the outputs; slave is the input block.
interface zaxxon_input_if;
    logic [10:0] ps2_key;
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic [4:0]  p1;
    logic [4:0]  p2;
    logic        start1;
    logic        start2;
    logic        coin1;

    modport master (
        output ps2_key, joy1, joy2,
        input  p1, p2, start1, start2, coin1
    );

    modport slave (
        input  ps2_key, joy1, joy2,
        output p1, p2, start1, start2, coin1
    );
endinterface

// File: rtl/zaxxon_input.sv
// zaxxon_input
// Merges PS/2 keyboard events and two joysticks into the Zaxxon control inputs
// and shapes the coin request into a fixed-length coin pulse.
// Ports:
//   clk_sys : system clock (24 MHz), sole clock
//   reset_n : asynchronous active-low reset
//   bus     : zaxxon_input_if.slave (ps2_key/joy1/joy2 in; p1/p2/start1/start2/coin1 out)
// Parameters:
//   COIN_PULSE   : coin1 high time in clk_sys cycles (2 .. 2^20-1)
//   SOCD_NEUTRAL : 1 = opposing directions held together resolve to neutral
module zaxxon_input #(
    parameter int COIN_PULSE   = 240000,
    parameter int SOCD_NEUTRAL = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    zaxxon_input_if.slave    bus
);

    localparam logic [19:0] PULSE_LOAD = 20'(COIN_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_e;

    // Keyboard event decode
    logic       tog_q;
    logic       key_evt;
    logic       key_pressed;
    logic [7:0] key_code;

    // Keyboard latches; bit order of the direction latches matches the output
    // word {fire, up, down, left, right}.
    logic [4:0] kp1_q;
    logic [4:0] kp2_q;
    logic       kstart1_q;
    logic       kstart2_q;
    logic       kcoin_a_q;
    logic       kcoin_b_q;

    logic [4:0] raw_ctrl;
    logic [4:0] p_d;
    logic [4:0] p_q;
    logic       start1_d;
    logic       start1_q;
    logic       start2_d;
    logic       start2_q;
    logic       coin_req;

    coin_state_e state_q;
    logic [19:0] cnt_q;
    logic        coin1_q;

    // Input bits with no function in this block.
    logic unused_bits;
    assign unused_bits = ^{bus.ps2_key[8], bus.joy1[15:9], bus.joy1[5],
                           bus.joy2[15:9], bus.joy2[5]};

    // An event is a change of the toggle bit against last cycle's sample.
    assign key_evt     = bus.ps2_key[10] ^ tog_q;
    assign key_pressed = bus.ps2_key[9];
    assign key_code    = bus.ps2_key[7:0];

    // Clears both members of an opposing pair when they are held together.
    function automatic logic [4:0] resolve_socd(input logic [4:0] raw);
        logic [4:0] res;
        res = raw;
        if (SOCD_NEUTRAL != 0) begin
            if (res[1] && res[0]) res[1:0] = 2'b00;
            if (res[3] && res[2]) res[3:2] = 2'b00;
        end
        return res;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            kp1_q     <= '0;
            kp2_q     <= '0;
            kstart1_q <= 1'b0;
            kstart2_q <= 1'b0;
            kcoin_a_q <= 1'b0;
            kcoin_b_q <= 1'b0;
        end else begin
            tog_q <= bus.ps2_key[10];
            if (key_evt) begin
                case (key_code)
                    8'h75:        kp1_q[3]  <= key_pressed;
                    8'h72:        kp1_q[2]  <= key_pressed;
                    8'h6B:        kp1_q[1]  <= key_pressed;
                    8'h74:        kp1_q[0]  <= key_pressed;
                    8'h14:        kp1_q[4]  <= key_pressed;
                    8'h2D:        kp2_q[3]  <= key_pressed;
                    8'h2B:        kp2_q[2]  <= key_pressed;
                    8'h23:        kp2_q[1]  <= key_pressed;
                    8'h34:        kp2_q[0]  <= key_pressed;
                    8'h1C:        kp2_q[4]  <= key_pressed;
                    8'h05, 8'h16: kstart1_q <= key_pressed;
                    8'h06, 8'h1E: kstart2_q <= key_pressed;
                    8'h76, 8'h2E: kcoin_a_q <= key_pressed;
                    8'h36:        kcoin_b_q <= key_pressed;
                    default: ;
                endcase
            end
        end
    end

    // Upright and cocktail share one control set, so both players merge.
    assign raw_ctrl = kp1_q | bus.joy1[4:0] | kp2_q | bus.joy2[4:0];
    assign p_d      = resolve_socd(raw_ctrl);
    assign start1_d = kstart1_q | bus.joy1[6] | bus.joy2[6];
    assign start2_d = kstart2_q | bus.joy1[7] | bus.joy2[7];
    assign coin_req = kcoin_a_q | kcoin_b_q | bus.joy1[8] | bus.joy2[8];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p_q      <= '0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
        end else begin
            p_q      <= p_d;
            start1_q <= start1_d;
            start2_q <= start2_d;
        end
    end

    // Coin shaper: the pulse length is fixed by the counter alone; the request
    // is only looked at in IDLE and HOLD, so a held or re-glitched request can
    // neither extend nor repeat a pulse until it has dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coin1_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (coin_req) begin
                        state_q <= PULSE;
                        cnt_q   <= PULSE_LOAD;
                        coin1_q <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == 20'd0) begin
                        state_q <= HOLD;
                        coin1_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 20'd1;
                    end
                end
                HOLD: begin
                    coin1_q <= 1'b0;
                    if (!coin_req) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    coin1_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p1     = p_q;
    assign bus.p2     = p_q;
    assign bus.start1 = start1_q;
    assign bus.start2 = start2_q;
    assign bus.coin1  = coin1_q;

endmodule

// File: tb/tb_zaxxon_input.sv
module tb_zaxxon_input;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_sys = ~clk_sys;

    zaxxon_input_if bus ();

    zaxxon_input #(
        .COIN_PULSE   (8),
        .SOCD_NEUTRAL (1)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Output word seen as {coin1, start2, start1, p2, p1}.
    logic [12:0] dut_o;
    assign dut_o = {bus.coin1, bus.start2, bus.start1, bus.p2, bus.p1};

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [12:0] ov(input logic c, input logic s2,
                                       input logic s1, input logic [4:0] p);
        return {c, s2, s1, p, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expectation for the output sampled dc cycles after the current edge.
    task automatic push(input int dc, input string tag, input logic [12:0] v);
        exp_t e;
        e.cyc = cyc + dc;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk_sys) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, 32'(dut_o), 32'(mon_e.val));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic key(input logic pr, input logic [7:0] code, input logic ext = 1'b0);
        bus.ps2_key = {~bus.ps2_key[10], pr, ext, code};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Toggle bit held high through reset with fire pressed: one event on release.
        bus.ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
        bus.joy1    = '0;
        bus.joy2    = '0;
        tick(3);
        chk("reset_out", 32'(dut_o), 32'd0);
        reset_n = 1'b1;
        push(1, "held_tog_lat", 13'd0);
        push(2, "held_tog", ov(0, 0, 0, 5'b10000));
        push(4, "held_tog_once", ov(0, 0, 0, 5'b10000));
        drain();
        key(0, 8'h14);
        push(2, "fire_rel", 13'd0);
        drain();

        key(1, 8'h75);
        push(1, "up_lat", 13'd0);
        push(2, "up_press", ov(0, 0, 0, 5'b01000));
        drain();
        key(0, 8'h75);
        push(2, "up_rel", 13'd0);
        drain();

        key(1, 8'h6B, 1'b1);
        push(2, "left_ext", ov(0, 0, 0, 5'b00010));
        drain();
        key(0, 8'h6B);
        push(2, "left_rel", 13'd0);
        drain();

        key(1, 8'h2D);
        push(2, "p2_up", ov(0, 0, 0, 5'b01000));
        drain();
        key(1, 8'h2B);
        push(2, "p2_updown_socd", 13'd0);
        drain();
        key(0, 8'h2D);
        push(2, "p2_down", ov(0, 0, 0, 5'b00100));
        drain();
        key(0, 8'h2B);
        push(2, "p2_down_rel", 13'd0);
        drain();

        bus.joy1 = 16'h0001;
        bus.joy2 = 16'h0002;
        push(1, "socd_lr", 13'd0);
        drain();
        bus.joy2 = 16'h0000;
        push(1, "socd_right", ov(0, 0, 0, 5'b00001));
        drain();
        bus.joy1 = 16'h0000;
        push(1, "joy_clr", 13'd0);
        drain();

        bus.joy2 = 16'h001A;
        push(1, "joy2_mix", ov(0, 0, 0, 5'b11010));
        drain();
        bus.joy2 = 16'h0000;
        push(1, "joy2_clr", 13'd0);
        drain();

        // Joystick is one cycle, keyboard two.
        key(1, 8'h14);
        bus.joy1 = 16'h0008;
        push(1, "or_joy", ov(0, 0, 0, 5'b01000));
        push(2, "or_key", ov(0, 0, 0, 5'b11000));
        drain();
        key(0, 8'h14);
        bus.joy1 = 16'h0000;
        push(1, "or_joy_off", ov(0, 0, 0, 5'b10000));
        push(2, "or_key_off", 13'd0);
        drain();

        key(1, 8'h05);
        push(2, "start1_05", ov(0, 0, 1, 5'b0));
        drain();
        key(0, 8'h16);
        push(2, "start1_16rel", 13'd0);
        drain();
        key(1, 8'h99);
        push(1, "unknown_a", 13'd0);
        push(2, "unknown_b", 13'd0);
        drain();
        key(0, 8'h99);
        tick(1);
        key(1, 8'h1E);
        push(2, "start2_1e", ov(0, 1, 0, 5'b0));
        drain();
        key(0, 8'h06);
        push(2, "start2_06rel", 13'd0);
        drain();
        bus.joy1 = 16'h0080;
        bus.joy2 = 16'h0040;
        push(1, "joy_starts", ov(0, 1, 1, 5'b0));
        drain();
        bus.joy1 = 16'h0000;
        bus.joy2 = 16'h0000;
        push(1, "joy_starts_clr", 13'd0);
        drain();

        // Held coin request: one 8-cycle pulse.
        bus.joy1 = 16'h0100;
        for (int i = 1; i <= 100; i++) push(i, "coin_hold", ov(i <= 8, 0, 0, 5'b0));
        drain();
        bus.joy1 = 16'h0000;
        for (int i = 1; i <= 4; i++) push(i, "coin_rel", 13'd0);
        drain();
        bus.joy1 = 16'h0100;
        for (int i = 1; i <= 12; i++) push(i, "coin_again", ov(i <= 8, 0, 0, 5'b0));
        drain();
        bus.joy1 = 16'h0000;
        for (int i = 1; i <= 3; i++) push(i, "coin_again_rel", 13'd0);
        drain();

        // One-cycle glitch, then a second glitch inside the pulse.
        bus.joy1 = 16'h0100;
        for (int i = 1; i <= 16; i++) push(i, "coin_glitch", ov(i <= 8, 0, 0, 5'b0));
        tick(1);
        bus.joy1 = 16'h0000;
        tick(3);
        bus.joy1 = 16'h0100;
        tick(1);
        bus.joy1 = 16'h0000;
        drain();

        // Keyboard coin A: latch adds one cycle before the FSM sees it.
        key(1, 8'h76);
        for (int i = 1; i <= 12; i++) push(i, "coin_key", ov(i >= 2 && i <= 9, 0, 0, 5'b0));
        drain();
        key(0, 8'h2E);
        for (int i = 1; i <= 4; i++) push(i, "coin_key_rel", 13'd0);
        drain();

        // Reset asserted in the 4th pulse cycle.
        bus.joy1 = 16'h0100;
        for (int i = 1; i <= 3; i++) push(i, "coin_pre_rst", ov(1, 0, 0, 5'b0));
        drain();
        chk("coin_c4", 32'(bus.coin1), 32'd1);
        bus.joy1 = 16'h0000;
        reset_n  = 1'b0;
        #1;
        chk("async_rst_coin", 32'(bus.coin1), 32'd0);
        tick(2);
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) push(i, "post_rst", 13'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
